// File: rtl/cube_move_queue.sv
// cube_move_queue: maps USB HID keycodes to cube face-turn moves and queues them
// in a small FIFO that drains through a valid/ready handshake. Rev 1.0
`default_nettype none

module cube_move_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          Reset_h,
  input  logic [7:0]    keycode,
  input  logic          move_ready,
  output logic          move_valid,
  output logic [2:0]    move_face,
  output logic          move_ccw,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [7:0]    kc_r;
  logic [7:0]    kc_p;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic          is_move;
  logic          is_clear;
  logic [2:0]    dec_face;
  logic          dec_ccw;
  logic          key_changed;
  logic          move_ev;
  logic          clear_ev;
  logic          pop;
  logic          push_ok;
  logic [AW:0]   count_next;

  always_comb begin
    is_move  = 1'b1;
    is_clear = 1'b0;
    dec_face = 3'd0;
    dec_ccw  = 1'b0;
    case (kc_r)
      8'h18: dec_face = 3'd0;
      8'h07: dec_face = 3'd1;
      8'h0F: dec_face = 3'd2;
      8'h15: dec_face = 3'd3;
      8'h09: dec_face = 3'd4;
      8'h05: dec_face = 3'd5;
      // digit keys '1'..'6' select the prime turn of U,D,L,R,F,B in order
      8'h1E: begin dec_face = 3'd0; dec_ccw = 1'b1; end
      8'h1F: begin dec_face = 3'd1; dec_ccw = 1'b1; end
      8'h20: begin dec_face = 3'd2; dec_ccw = 1'b1; end
      8'h21: begin dec_face = 3'd3; dec_ccw = 1'b1; end
      8'h22: begin dec_face = 3'd4; dec_ccw = 1'b1; end
      8'h23: begin dec_face = 3'd5; dec_ccw = 1'b1; end
      8'h2C: begin is_move = 1'b0; is_clear = 1'b1; end
      default: is_move = 1'b0;
    endcase
  end

  assign key_changed = (kc_r != kc_p);
  assign move_ev     = key_changed && is_move;
  assign clear_ev    = key_changed && is_clear;

  assign move_valid  = (count != '0);
  assign pop         = move_valid && move_ready;
  // A full queue still takes a push when the head leaves in the same cycle
  assign push_ok     = move_ev && ((count < (AW+1)'(DEPTH)) || pop);
  assign count_next  = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  assign move_face   = move_valid ? mem[rd_ptr][3:1] : 3'd0;
  assign move_ccw    = move_valid ? mem[rd_ptr][0]   : 1'b0;

  always_ff @(posedge clk) begin
    if (Reset_h) begin
      kc_r     <= 8'h00;
      kc_p     <= 8'h00;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 4'd0;
      end
    end else begin
      kc_r <= keycode;
      kc_p <= kc_r;
      if (clear_ev) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= {dec_face, dec_ccw};
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count_next;
        if (move_ev && !push_ok) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cube_move_queue.sv
// tb_cube_move_queue: directed self-checking bench for cube_move_queue. Rev 1.0
`default_nettype none

module tb_cube_move_queue;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          Reset_h;
  logic [7:0]    keycode;
  logic          move_ready;
  logic          move_valid;
  logic [2:0]    move_face;
  logic          move_ccw;
  logic [AW:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  cube_move_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .Reset_h    (Reset_h),
    .keycode    (keycode),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_face  (move_face),
    .move_ccw   (move_ccw),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [2:0] face, input logic ccw);
    check({tag, "_valid"}, 32'(move_valid), 32'd1);
    check({tag, "_face"},  32'(move_face),  32'(face));
    check({tag, "_ccw"},   32'(move_ccw),   32'(ccw));
  endtask

  // press a key and let it reach the queue (two edges)
  task automatic press(input logic [7:0] kc);
    keycode = kc;
    tick(2);
  endtask

  logic [7:0] codes [9];
  logic [2:0] faces [9];
  logic       ccws  [9];

  initial begin
    codes = '{8'h18, 8'h07, 8'h0F, 8'h15, 8'h09, 8'h05, 8'h1E, 8'h1F, 8'h20};
    faces = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    ccws  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    Reset_h    = 1'b1;
    keycode    = 8'h00;
    move_ready = 1'b0;
    tick(3);
    check("rst_count",    32'(count),      32'd0);
    check("rst_valid",    32'(move_valid), 32'd0);
    check("rst_face",     32'(move_face),  32'd0);
    check("rst_ccw",      32'(move_ccw),   32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    Reset_h = 1'b0;
    tick(2);

    // single held key: one entry, valid two edges after the change
    keycode = 8'h18;
    tick(1);
    check("lat_e0_valid", 32'(move_valid), 32'd0);
    tick(1);
    check_head("lat_e1", 3'd0, 1'b0);
    check("lat_e1_count", 32'(count), 32'd1);
    tick(100);
    check("held_count", 32'(count), 32'd1);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    check("drain1_count", 32'(count), 32'd0);
    check("drain1_valid", 32'(move_valid), 32'd0);
    keycode = 8'h00;
    tick(2);
    press(8'h04);
    check("unmapped_count", 32'(count), 32'd0);
    press(8'h00);

    // release/re-press and direct change between mapped codes
    press(8'h15);
    press(8'h00);
    press(8'h15);
    press(8'h21);
    check("seq_count", 32'(count), 32'd3);
    tick(3);
    check_head("hold", 3'd3, 1'b0);
    move_ready = 1'b1;
    check_head("seq_h0", 3'd3, 1'b0);
    tick(1);
    check_head("seq_h1", 3'd3, 1'b0);
    check("seq_cnt1", 32'(count), 32'd2);
    tick(1);
    check_head("seq_h2", 3'd3, 1'b1);
    tick(1);
    check("seq_empty_valid", 32'(move_valid), 32'd0);
    check("seq_empty_count", 32'(count), 32'd0);
    move_ready = 1'b0;

    // nine presses into an 8-deep queue
    for (int i = 0; i < 9; i++) press(codes[i]);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    move_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("ovf_drain%0d", i), faces[i], ccws[i]);
      tick(1);
    end
    check("ovf_drained_valid", 32'(move_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    move_ready = 1'b0;
    press(8'h2C);
    check("clr_ovf", 32'(overflow), 32'd0);

    // full queue with push and pop in the same cycle
    for (int i = 0; i < 8; i++) press(codes[i]);
    check("full_count", 32'(count), 32'd8);
    check("full_ovf",   32'(overflow), 32'd0);
    keycode = 8'h20;
    tick(1);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_ovf",   32'(overflow), 32'd0);
    check_head("fullpp_head", 3'd1, 1'b0);
    press(8'h21);
    check("full_drop_ovf", 32'(overflow), 32'd1);
    move_ready = 1'b1;
    tick(5);
    move_ready = 1'b0;
    check("pre_clr_count", 32'(count), 32'd3);
    check_head("pre_clr_head", 3'd0, 1'b1);

    // CLEAR with a pop in the same cycle
    keycode = 8'h2C;
    tick(1);
    check("clr_e0_count", 32'(count), 32'd3);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(move_valid), 32'd0);
    check("clr_ovf2",  32'(overflow), 32'd0);

    // reset mid-operation with ready toggling
    for (int i = 0; i < 5; i++) press(codes[i]);
    check("pre_rst_count", 32'(count), 32'd5);
    keycode    = 8'h00;
    move_ready = 1'b1;
    Reset_h    = 1'b1;
    tick(1);
    check("mid_rst_count", 32'(count),      32'd0);
    check("mid_rst_valid", 32'(move_valid), 32'd0);
    check("mid_rst_face",  32'(move_face),  32'd0);
    check("mid_rst_ccw",   32'(move_ccw),   32'd0);
    check("mid_rst_ovf",   32'(overflow),   32'd0);
    Reset_h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      move_ready = ~move_ready;
      tick(1);
    end
    check("post_rst_count", 32'(count), 32'd0);
    move_ready = 1'b0;

    // key held through reset release: push at the second edge after release
    Reset_h = 1'b1;
    keycode = 8'h09;
    tick(2);
    Reset_h = 1'b0;
    tick(1);
    check("hold_rst_e1_valid", 32'(move_valid), 32'd0);
    tick(1);
    check_head("hold_rst_e2", 3'd4, 1'b0);
    tick(5);
    check("hold_rst_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
